// File: rtl/cache_controller_pkg.sv
// Shared defaults and FSM encoding for the direct-mapped write-through cache controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_controller_pkg;

    localparam int CC_ADD_WIDTH   = 10;
    localparam int CC_DATA_WIDTH  = 32;
    localparam int CC_INDEX_WIDTH = 5;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2,
        DONE    = 2'd3
    } cc_state_e;

endpackage

// File: rtl/cache_controller_array.sv
// Valid/tag/data line storage: combinational lookup, one synchronous write port.
// Latency: lookup 0 cycles, write visible the cycle after wr_en.
// Backpressure: none; a write is always accepted.
module cache_array #(
    parameter int INDEX_WIDTH = 5,
    parameter int TAG_WIDTH   = 5,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic                   rd_valid,
    output logic [TAG_WIDTH-1:0]   rd_tag,
    output logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  logic [DATA_WIDTH-1:0]  wr_data
);

    localparam int LINES = 1 << INDEX_WIDTH;

    logic [LINES-1:0]      valid_q;
    logic [TAG_WIDTH-1:0]  tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [LINES];

    // Valid bits are the only state that must clear on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            valid_q <= '0;
        else if (wr_en)
            valid_q[wr_index] <= 1'b1;
    end

    // Tag and data payload; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    // Combinational lookup so IDLE can answer a hit in the request cycle.
    always_comb begin
        rd_valid = valid_q[rd_index];
        rd_tag   = tag_mem[rd_index];
        rd_data  = data_mem[rd_index];
    end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, one-word-line, write-through, no-write-allocate cache controller.
// Latency: read hit 0 cycles; miss/write stall 3 cycles with a 1-cycle memory, response in 4th.
// Backpressure: stall holds the CPU request; memory side waits on mem_ready.
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int ADD_WIDTH   = CC_ADD_WIDTH,
    parameter int DATA_WIDTH  = CC_DATA_WIDTH,
    parameter int INDEX_WIDTH = CC_INDEX_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADD_WIDTH-1:0]  cpu_add,
    input  logic [DATA_WIDTH-1:0] cpu_write_data,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    output logic [DATA_WIDTH-1:0] cpu_read_data,
    output logic                  stall,
    output logic [ADD_WIDTH-1:0]  mem_add,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_ready,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    localparam int TAG_WIDTH = ADD_WIDTH - INDEX_WIDTH;

    cc_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] resp_q;
    logic                  resp_we;
    logic                  hit_inc, miss_inc;

    logic [INDEX_WIDTH-1:0] req_index;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic                   line_valid;
    logic [TAG_WIDTH-1:0]   line_tag;
    logic [DATA_WIDTH-1:0]  line_data;
    logic                   line_hit;
    logic                   arr_we;
    logic [DATA_WIDTH-1:0]  arr_wdata;

    assign req_index = cpu_add[INDEX_WIDTH-1:0];
    assign req_tag   = cpu_add[ADD_WIDTH-1:INDEX_WIDTH];
    assign line_hit  = line_valid && (line_tag == req_tag);

    cache_array #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_index (req_index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (arr_we),
        .wr_index (req_index),
        .wr_tag   (req_tag),
        .wr_data  (arr_wdata)
    );

    // State register; reset lands in IDLE so memory strobes drop at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state, CPU/memory strobes and line-write control.
    always_comb begin
        state_d        = state_q;
        stall          = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_add        = cpu_add;
        mem_write_data = cpu_write_data;
        cpu_read_data  = resp_q;
        arr_we         = 1'b0;
        arr_wdata      = mem_read_data;
        resp_we        = 1'b0;
        hit_inc        = 1'b0;
        miss_inc       = 1'b0;
        case (state_q)
            IDLE: begin
                cpu_read_data = line_data;
                if (cpu_write) begin
                    // Write wins over a simultaneous read.
                    stall    = 1'b1;
                    hit_inc  = line_hit;
                    miss_inc = !line_hit;
                    state_d  = WR_THRU;
                end else if (cpu_read) begin
                    if (line_hit) begin
                        hit_inc = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        miss_inc = 1'b1;
                        state_d  = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                stall    = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    arr_we  = 1'b1;
                    resp_we = 1'b1;
                    state_d = DONE;
                end
            end
            WR_THRU: begin
                stall     = 1'b1;
                mem_write = 1'b1;
                arr_wdata = cpu_write_data;
                if (mem_ready) begin
                    // No-write-allocate: only a resident line is refreshed.
                    arr_we  = line_hit;
                    state_d = DONE;
                end
            end
            DONE: begin
                // One quiet cycle lets mem_ready fall before the next request.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Response register holds the fill data for the DONE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            resp_q <= '0;
        else if (resp_we)
            resp_q <= mem_read_data;
    end

    // Saturating hit/miss counters, stepped only on accepted IDLE requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc && hit_count != CNT_MAX)
                hit_count <= hit_count + 16'd1;
            if (miss_inc && miss_count != CNT_MAX)
                miss_count <= miss_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized and directed bench for cache_controller against a line/memory reference model.
// Latency: each request is followed until stall drops, bounded to 20 cycles.
// Backpressure: request held while stall is high; memory answers one cycle after a request.
module tb_cache_controller;

    logic        clk;
    logic        reset;
    logic [9:0]  cpu_add;
    logic [31:0] cpu_write_data;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_read_data;
    logic        stall;
    logic [9:0]  mem_add;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;
    logic        mem_ready;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    cache_controller dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_add        (cpu_add),
        .cpu_write_data (cpu_write_data),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .cpu_read_data  (cpu_read_data),
        .stall          (stall),
        .mem_add        (mem_add),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data),
        .mem_ready      (mem_ready),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main memory: samples a request at the edge, answers the following cycle.
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        mem_ready     <= mem_read | mem_write;
        mem_read_data <= mem[mem_add];
        if (mem_write)
            mem[mem_add] <= mem_write_data;
    end

    // Reference model: what the cache should hold and what memory should contain.
    bit          m_valid [32];
    logic [4:0]  m_tag   [32];
    logic [31:0] m_data  [32];
    logic [31:0] ref_mem [1024];
    int          m_hits;
    int          m_misses;

    int n_tests;
    int n_fail;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Issue one request, follow it to completion, and compare against the model.
    task automatic do_req(input bit rd, input bit wr, input logic [9:0] addr, input logic [31:0] wdata);
        int          idx;
        logic [4:0]  tg;
        bit          hit;
        int          exp_stall;
        int          nstall;
        bit          done;
        bit          saw_rd, saw_wr, add_ok, wd_ok;
        logic [31:0] got;
        idx       = int'(addr[4:0]);
        tg        = addr[9:5];
        hit       = m_valid[idx] && (m_tag[idx] == tg);
        exp_stall = (wr || !hit) ? 3 : 0;
        cpu_add        = addr;
        cpu_read       = rd;
        cpu_write      = wr;
        cpu_write_data = wdata;
        nstall = 0; done = 0; saw_rd = 0; saw_wr = 0; add_ok = 1; wd_ok = 1; got = '0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                if (mem_add !== addr) add_ok = 0;
            end
            if (mem_read) saw_rd = 1;
            if (mem_write) begin
                saw_wr = 1;
                if (mem_write_data !== wdata) wd_ok = 0;
            end
            if (!stall) begin
                got  = cpu_read_data;
                done = 1;
            end else begin
                nstall++;
            end
        end
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        // Update the model from the rules: write-through, no-write-allocate, fill on read miss.
        if (wr) begin
            ref_mem[addr] = wdata;
            if (hit) m_data[idx] = wdata;
        end else if (rd && !hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_data[idx]  = ref_mem[addr];
        end
        if (rd || wr) begin
            if (hit) m_hits   = sat16(m_hits + 1);
            else     m_misses = sat16(m_misses + 1);
        end
        check_val("completed", 32'(done), 32'd1);
        check_val("stall_cycles", nstall, exp_stall);
        check_val("mem_read_seen", 32'(saw_rd), 32'(rd && !wr && !hit));
        check_val("mem_write_seen", 32'(saw_wr), 32'(wr));
        check_val("mem_add", 32'(add_ok), 32'd1);
        check_val("mem_write_data", 32'(wd_ok), 32'd1);
        if (rd && !wr) check_val("cpu_read_data", got, m_data[idx]);
        check_val("hit_count", 32'(hit_count), m_hits);
        check_val("miss_count", 32'(miss_count), m_misses);
    endtask

    initial begin
        logic [9:0]  a;
        logic [31:0] d;
        int          r;
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 1024; i++) begin
            d = $urandom;
            mem[i]     = d;
            ref_mem[i] = d;
        end
        mem[10'h025]     = 32'hDEADBEEF;
        ref_mem[10'h025] = 32'hDEADBEEF;
        model_reset();
        cpu_add = '0; cpu_write_data = '0; cpu_read = 0; cpu_write = 0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_val("rst_stall", 32'(stall), 32'd0);
        check_val("rst_mem_strobes", 32'({mem_read, mem_write}), 32'd0);
        check_val("rst_hit_count", 32'(hit_count), 32'd0);
        check_val("rst_miss_count", 32'(miss_count), 32'd0);
        @(posedge clk);
        #1;

        // Miss then hit on the same address; conflict misses on a shared index.
        do_req(1, 0, 10'h025, '0);
        do_req(1, 0, 10'h025, '0);
        do_req(1, 0, 10'h045, '0);
        do_req(1, 0, 10'h025, '0);
        do_req(1, 0, 10'h025, '0);
        // Write hit updates the line; write miss leaves the cache alone.
        do_req(0, 1, 10'h025, 32'h12345678);
        do_req(1, 0, 10'h025, '0);
        do_req(0, 1, 10'h3FF, 32'hCAFEF00D);
        do_req(1, 0, 10'h3FF, '0);
        // Read and write together: only the write happens.
        do_req(1, 1, 10'h010, 32'hA5A5A5A5);
        do_req(1, 0, 10'h010, '0);

        // Reset in the middle of a read miss.
        cpu_add = 10'h0AA; cpu_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("rdmiss_mem_read", 32'(mem_read), 32'd1);
        #1 reset = 1'b0;
        #1;
        check_val("rst_drop_mem_read", 32'(mem_read), 32'd0);
        cpu_read = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_val("rst2_counts", 32'({hit_count, miss_count}), 32'd0);
        @(posedge clk);
        #1;
        do_req(1, 0, 10'h0AA, '0);
        do_req(1, 0, 10'h025, '0);

        // Randomized traffic over a few indices and tags so hits and conflicts both occur.
        for (int t = 0; t < 200; t++) begin
            a = 10'(($urandom_range(0, 3) << 5) | $urandom_range(0, 3));
            d = $urandom;
            r = $urandom_range(0, 9);
            if (r < 6)       do_req(1, 0, a, d);
            else if (r < 9)  do_req(0, 1, a, d);
            else             do_req(1, 1, a, d);
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                check_val("idle_no_stall", 32'(stall), 32'd0);
                @(posedge clk);
                #1;
            end
        end

        // Saturate the hit counter with back-to-back hits.
        do_req(1, 0, 10'h025, '0);
        cpu_add  = 10'h025;
        cpu_read = 1'b1;
        repeat (70000) @(posedge clk);
        #1 cpu_read = 1'b0;
        m_hits = sat16(m_hits + 70000);
        @(negedge clk);
        check_val("hit_saturate", 32'(hit_count), m_hits);
        check_val("hit_saturate_ffff", 32'(hit_count), 32'h0000FFFF);
        check_val("miss_after_sat", 32'(miss_count), m_misses);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 The block SHALL have parameter ADD_WIDTH, default 10, meaning word address width on both CPU and memory sides.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data word width.
REQ-003 The block SHALL have parameter INDEX_WIDTH, default 5, meaning the line index width (32 lines; tag width = ADD_WIDTH-INDEX_WIDTH).
REQ-004 The block SHALL have port clk  input  1  meaning the single clock, rising edge.
REQ-005 The block SHALL have port reset  input  1  meaning the reset: asynchronous, active-low.
REQ-006 The block SHALL have ports cpu_add  input  ADD_WIDTH; cpu_write_data  input  DATA_WIDTH; cpu_read  input  1; cpu_write  input  1, meaning the CPU request, held stable while stall=1.
REQ-007 The block SHALL have ports cpu_read_data  output  DATA_WIDTH and stall  output  1, meaning the CPU response and the hold-request indicator.
REQ-008 The block SHALL have ports mem_add  output  ADD_WIDTH; mem_write_data  output  DATA_WIDTH; mem_read  output  1; mem_write  output  1, meaning the requests to main memory.
REQ-009 The block SHALL have ports mem_read_data  input  DATA_WIDTH and mem_ready  input  1, meaning the main-memory response; mem_ready rises one cycle after memory samples a request and stays high while that request is held.
REQ-010 The block SHALL have ports hit_count  output  16 and miss_count  output  16, meaning the saturating performance counters.

Function
REQ-011 Organisation SHALL be direct-mapped, one word per line, write-through, no-write-allocate; index = cpu_add[INDEX_WIDTH-1:0], tag = upper bits.
REQ-012 The FSM SHALL have states IDLE, RD_MISS, WR_THRU, DONE.
REQ-013 IDLE: read hit (valid and tag match) -> stall=0, cpu_read_data = line data combinationally in the same cycle, hit_count+1, stay IDLE.
REQ-014 IDLE: read miss -> stall=1, miss_count+1, next RD_MISS.
REQ-015 IDLE: cpu_write (hit or miss) -> stall=1, next WR_THRU; write hits count as hits, write misses as misses.
REQ-016 When cpu_read and cpu_write are both high, write SHALL take priority (read ignored).
REQ-017 RD_MISS: mem_read=1, mem_add=cpu_add, stall=1; on mem_ready=1, the line SHALL be written (valid=1, tag, data=mem_read_data), mem_read_data SHALL be captured into a response register, and next state is DONE.
REQ-018 WR_THRU: mem_write=1, mem_add=cpu_add, mem_write_data=cpu_write_data, stall=1; on mem_ready=1, if the line hits, its data SHALL be updated to cpu_write_data; next DONE; a write miss SHALL leave the line untouched.
REQ-019 DONE: mem_read=mem_write=0, stall=0, cpu_read_data = response register (reads only); new requests are not evaluated; next IDLE unconditionally (guarantees mem_ready low before the next request).
REQ-020 Miss and write latency: stall high for exactly 3 cycles (IDLE, RD_MISS x2 with a 1-cycle memory), response in the 4th cycle.
REQ-021 In IDLE and DONE, mem_read and mem_write SHALL be 0; mem_add and mem_write_data are don't-care when both are 0.
REQ-022 Counters SHALL saturate at 16'hFFFF and increment only in IDLE on an accepted request.
REQ-023 With no cpu_read or cpu_write in IDLE: stall=0 and no state change.

Reset
REQ-024 Reset low SHALL asynchronously force: state IDLE, all valid bits 0, response register 0, hit_count=miss_count=0; tag/data storage need not be reset.
REQ-025 Reset asserted mid-miss SHALL drop mem_read/mem_write immediately, with no line written.

Structure
REQ-026 A shared package SHALL hold ADD_WIDTH, DATA_WIDTH, INDEX_WIDTH defaults and the FSM state encoding.
REQ-027 A sub-module cache_array SHALL hold the valid/tag/data storage with combinational lookup and a single synchronous write port.

Verification
REQ-028 Reset, then read 0x025 with memory holding 0xDEADBEEF -> stall 3 cycles, mem_read seen, cpu_read_data=0xDEADBEEF in DONE, miss_count=1.
REQ-029 Repeat read 0x025 -> stall=0 same cycle, data 0xDEADBEEF, no mem_read, hit_count=1.
REQ-030 Read 0x045 (same index 5, new tag) then 0x025 -> both miss, miss_count+2, and the line is replaced each time.
REQ-031 Write 0x12345678 to cached 0x025 -> mem_write with that data, then read 0x025 hits with 0x12345678; write to uncached 0x3FF -> the subsequent read misses.
REQ-032 cpu_read and cpu_write both high at 0x010 -> only mem_write issued.
REQ-033 Reset pulse during RD_MISS -> mem_read low immediately, and a later read of the same address misses; drive 70000 hits -> hit_count=0xFFFF.
